data_pipe_fifo: RTL and testbench

- Parametrised successor to the fixed 8-bit DATA_I/DATA_O top-level data path.
- Replaces the single register stage with a DEPTH-entry first-word-fall-through buffer.
- Uses valid/ready handshakes on both sides, synchronous flush, occupancy/almost-full status and a peak-occupancy watermark.
- Sits between a producer and consumer in the TOP data path; the TEST_TOP-style bench drives it directly.

---
 rtl/data_pipe_pkg.sv | 17 +
 rtl/data_pipe_ram.sv | 28 ++
 rtl/data_pipe_fifo.sv | 101 ++++++++++
 tb/tb_data_pipe_fifo.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/data_pipe_pkg.sv
// Shared constants and helpers for the data_pipe FIFO slice.
package data_pipe_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 4;

    // Ceiling log2, usable in parameter expressions.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/data_pipe_ram.sv
// WIDTH x DEPTH register array: one synchronous write port, asynchronous read.
module data_pipe_ram
    import data_pipe_pkg::*;
#(
    parameter int WIDTH = DATA_W_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // NOTE: storage has no reset; the pointers alone decide which entries are live.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/data_pipe_fifo.sv
// First-word-fall-through FIFO with valid/ready on both sides, flush and peak watermark.
module data_pipe_fifo
    import data_pipe_pkg::*;
#(
    parameter int WIDTH    = DATA_W_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int CW       = clog2(DEPTH) + 1
) (
    input  logic             CLK_I,
    input  logic             RST_I,
    input  logic [WIDTH-1:0] DATA_I,
    input  logic             VALID_I,
    output logic             READY_O,
    output logic [WIDTH-1:0] DATA_O,
    output logic             VALID_O,
    input  logic             READY_I,
    input  logic             FLUSH_I,
    output logic [CW-1:0]    COUNT_O,
    output logic             ALMOST_FULL_O,
    output logic [CW-1:0]    PEAK_O
);

    localparam int AW = clog2(DEPTH);

    logic [CW-1:0]    count_q, count_d;
    logic [CW-1:0]    peak_q, peak_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] rdata;
    logic             push, pop;

    // Flags depend on registered count only, so no input reaches an output combinationally.
    assign READY_O       = (count_q != CW'(DEPTH));
    assign VALID_O       = (count_q != '0);
    assign ALMOST_FULL_O = (count_q >= CW'(AF_LEVEL));
    assign COUNT_O       = count_q;
    assign PEAK_O        = peak_q;
    assign DATA_O        = VALID_O ? rdata : '0;

    assign push = VALID_I & READY_O;
    assign pop  = VALID_O & READY_I;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        count_d  = count_q;
        peak_d   = peak_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (FLUSH_I) begin
            count_d  = '0;
            peak_d   = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            if (count_d > peak_q) begin
                peak_d = count_d;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            count_q  <= '0;
            peak_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            count_q  <= count_d;
            peak_q   <= peak_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    data_pipe_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk_i   (CLK_I),
        .we_i    (push & ~FLUSH_I & ~RST_I),
        .waddr_i (wr_ptr_q),
        .wdata_i (DATA_I),
        .raddr_i (rd_ptr_q),
        .rdata_o (rdata)
    );

endmodule

// File: tb/tb_data_pipe_fifo.sv
// Directed self-checking bench for data_pipe_fifo (WIDTH=8, DEPTH=4, AF_LEVEL=3).
`timescale 1ns/1ps
module tb_data_pipe_fifo;

    logic       CLK_I;
    logic       RST_I;
    logic [7:0] DATA_I;
    logic       VALID_I;
    logic       READY_O;
    logic [7:0] DATA_O;
    logic       VALID_O;
    logic       READY_I;
    logic       FLUSH_I;
    logic [2:0] COUNT_O;
    logic       ALMOST_FULL_O;
    logic [2:0] PEAK_O;

    int n_checks = 0;
    int n_errors = 0;

    data_pipe_fifo #(
        .WIDTH    (8),
        .DEPTH    (4),
        .AF_LEVEL (3)
    ) dut (
        .CLK_I         (CLK_I),
        .RST_I         (RST_I),
        .DATA_I        (DATA_I),
        .VALID_I       (VALID_I),
        .READY_O       (READY_O),
        .DATA_O        (DATA_O),
        .VALID_O       (VALID_O),
        .READY_I       (READY_I),
        .FLUSH_I       (FLUSH_I),
        .COUNT_O       (COUNT_O),
        .ALMOST_FULL_O (ALMOST_FULL_O),
        .PEAK_O        (PEAK_O)
    );

    initial CLK_I = 1'b0;
    always #100 CLK_I = ~CLK_I;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1ns after it.
    task automatic tick();
        @(posedge CLK_I);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".ready"}, 32'(READY_O), 32'd1);
        check({tag, ".valid"}, 32'(VALID_O), 32'd0);
        check({tag, ".data"},  32'(DATA_O),  32'd0);
        check({tag, ".count"}, 32'(COUNT_O), 32'd0);
        check({tag, ".af"},    32'(ALMOST_FULL_O), 32'd0);
        check({tag, ".peak"},  32'(PEAK_O),  32'd0);
    endtask

    initial begin
        logic [7:0] exp_head;

        RST_I   = 1'b1;
        DATA_I  = 8'h00;
        VALID_I = 1'b0;
        READY_I = 1'b0;
        FLUSH_I = 1'b0;

        // Reset then single word
        tick();
        tick();
        check_reset_state("rst");
        RST_I = 1'b0;
        VALID_I = 1'b1;
        DATA_I  = 8'h01;
        tick();
        VALID_I = 1'b0;
        check("single.valid", 32'(VALID_O), 32'd1);
        check("single.data",  32'(DATA_O),  32'h01);
        check("single.count", 32'(COUNT_O), 32'd1);
        READY_I = 1'b1;
        tick();
        READY_I = 1'b0;
        check("single.pop_valid", 32'(VALID_O), 32'd0);
        check("single.pop_data",  32'(DATA_O),  32'h00);
        check("single.peak",      32'(PEAK_O),  32'd1);

        // Fill to full with consumer stalled
        for (int i = 0; i < 4; i++) begin
            VALID_I = 1'b1;
            DATA_I  = 8'h10 + 8'(i);
            tick();
            check($sformatf("fill%0d.count", i), 32'(COUNT_O), 32'(i + 1));
            check($sformatf("fill%0d.af", i), 32'(ALMOST_FULL_O), (i >= 2) ? 32'd1 : 32'd0);
            check($sformatf("fill%0d.ready", i), 32'(READY_O), (i == 3) ? 32'd0 : 32'd1);
        end
        check("fill.peak", 32'(PEAK_O), 32'd4);
        DATA_I = 8'h14;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("hold%0d.count", i), 32'(COUNT_O), 32'd4);
            check($sformatf("hold%0d.ready", i), 32'(READY_O), 32'd0);
        end

        // Drain from full with producer still offering 8'h14
        check("drain.head0", 32'(DATA_O), 32'h10);
        READY_I = 1'b1;
        tick();
        check("drain.count_after_full_pop", 32'(COUNT_O), 32'd3);
        check("drain.ready_reopens", 32'(READY_O), 32'd1);
        check("drain.head1", 32'(DATA_O), 32'h11);
        tick();
        VALID_I = 1'b0;
        check("drain.count_push_pop", 32'(COUNT_O), 32'd3);
        check("drain.head2", 32'(DATA_O), 32'h12);
        tick();
        check("drain.head3", 32'(DATA_O), 32'h13);
        tick();
        check("drain.head4", 32'(DATA_O), 32'h14);
        check("drain.count1", 32'(COUNT_O), 32'd1);
        tick();
        READY_I = 1'b0;
        check("drain.empty_valid", 32'(VALID_O), 32'd0);
        check("drain.empty_count", 32'(COUNT_O), 32'd0);
        check("drain.peak_kept", 32'(PEAK_O), 32'd4);

        // Steady-state streaming at occupancy 2
        VALID_I = 1'b1;
        DATA_I  = 8'h20;
        tick();
        DATA_I  = 8'h21;
        tick();
        check("stream.prefill", 32'(COUNT_O), 32'd2);
        READY_I = 1'b1;
        for (int i = 0; i < 20; i++) begin
            DATA_I   = 8'h30 + 8'(i);
            exp_head = (i < 2) ? (8'h20 + 8'(i)) : (8'h30 + 8'(i - 2));
            check($sformatf("stream%0d.data", i), 32'(DATA_O), 32'(exp_head));
            tick();
            check($sformatf("stream%0d.count", i), 32'(COUNT_O), 32'd2);
        end
        VALID_I = 1'b0;
        READY_I = 1'b0;
        check("stream.tail", 32'(DATA_O), 32'h42);

        // Flush with a concurrent push
        FLUSH_I = 1'b1;
        tick();
        FLUSH_I = 1'b0;
        check("flush0.count", 32'(COUNT_O), 32'd0);
        check("flush0.peak",  32'(PEAK_O),  32'd0);
        for (int i = 0; i < 3; i++) begin
            VALID_I = 1'b1;
            DATA_I  = 8'h40 + 8'(i);
            tick();
        end
        check("preflush.count", 32'(COUNT_O), 32'd3);
        check("preflush.peak",  32'(PEAK_O),  32'd3);
        FLUSH_I = 1'b1;
        DATA_I  = 8'hAA;
        tick();
        FLUSH_I = 1'b0;
        VALID_I = 1'b0;
        check_reset_state("flush");
        VALID_I = 1'b1;
        DATA_I  = 8'h66;
        tick();
        VALID_I = 1'b0;
        check("postflush.count", 32'(COUNT_O), 32'd1);
        check("postflush.head",  32'(DATA_O),  32'h66);
        READY_I = 1'b1;
        tick();
        READY_I = 1'b0;
        check("postflush.empty", 32'(VALID_O), 32'd0);

        // Reset mid-operation overriding flush, push and pop
        VALID_I = 1'b1;
        DATA_I  = 8'h70;
        tick();
        DATA_I  = 8'h71;
        tick();
        check("prerst.count", 32'(COUNT_O), 32'd2);
        RST_I   = 1'b1;
        FLUSH_I = 1'b1;
        READY_I = 1'b1;
        DATA_I  = 8'h77;
        tick();
        check_reset_state("midrst");
        RST_I   = 1'b0;
        FLUSH_I = 1'b0;
        READY_I = 1'b0;
        DATA_I  = 8'h55;
        tick();
        VALID_I = 1'b0;
        check("postrst.head",  32'(DATA_O),  32'h55);
        check("postrst.count", 32'(COUNT_O), 32'd1);
        check("postrst.peak",  32'(PEAK_O),  32'd1);
        READY_I = 1'b1;
        tick();
        READY_I = 1'b0;
        check("postrst.empty", 32'(VALID_O), 32'd0);
        check("postrst.data0", 32'(DATA_O),  32'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
